// File: rtl/bitcrush_restore.sv
// Restores bit-crushed audio on channels 1-3 with a one-pole smoother, y += (x - y) >>> k.
// Optional macro BITCRUSH_RESTORE_DITHER_EN adds LFSR dither before saturation.
module bitcrush_restore #(
  parameter int W    = 16,
  parameter int KMAX = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  input  logic [7:0]          jack
);

  localparam int KW = $clog2(KMAX + 1);

  typedef enum logic [1:0] {IDLE, CH1, CH2, CH3} state_t;

  state_t               state;
  logic                 s1, s2, s3;
  logic                 pulse;
  logic signed [W-1:0]  x1, x2, x3;
  logic signed [W-1:0]  y1, y2, y3;
  logic [KW-1:0]        k_r;
  logic [KW-1:0]        k_map;
  int                   cv;
  int                   k_raw;
  logic signed [W-1:0]  x_sel, y_sel;
  logic signed [W:0]    diff, step, sum;
  logic signed [W-1:0]  y_new;
  logic                 unused_jack;

  assign unused_jack = ^jack;
  assign sample_out0 = sample_in0;
  assign pulse       = s2 & ~s3;

  // 500 mV ladder on the CV, top threshold first.
  always_comb begin
    cv    = int'(sample_in0);
    k_raw = 0;
    if      (cv > 4 * 3500) k_raw = 7;
    else if (cv > 4 * 3000) k_raw = 6;
    else if (cv > 4 * 2500) k_raw = 5;
    else if (cv > 4 * 2000) k_raw = 4;
    else if (cv > 4 * 1500) k_raw = 3;
    else if (cv > 4 * 1000) k_raw = 2;
    else if (cv > 4 * 500)  k_raw = 1;
    k_map = (k_raw > KMAX) ? KW'(KMAX) : KW'(k_raw);
  end

`ifdef BITCRUSH_RESTORE_DITHER_EN
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic signed [W:0] dither;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dither  = {{(W - 3){lfsr[3]}}, lfsr[3:0]};
`endif

  // Single shared update path; the FSM state picks which channel feeds it.
  always_comb begin
    case (state)
      CH1:     begin x_sel = x1; y_sel = y1; end
      CH2:     begin x_sel = x2; y_sel = y2; end
      default: begin x_sel = x3; y_sel = y3; end
    endcase
    diff = {x_sel[W-1], x_sel} - {y_sel[W-1], y_sel};
    step = diff >>> k_r;
`ifdef BITCRUSH_RESTORE_DITHER_EN
    sum  = {y_sel[W-1], y_sel} + step + dither;
`else
    sum  = {y_sel[W-1], y_sel} + step;
`endif
    if (sum[W] != sum[W-1])
      y_new = sum[W] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
    else
      y_new = sum[W-1:0];
  end

  // NOTE: reset is sampled synchronously and all state uses non-blocking
  // assignments so every register sees pre-edge values within the same clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      x1          <= '0;
      x2          <= '0;
      x3          <= '0;
      k_r         <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
`ifdef BITCRUSH_RESTORE_DITHER_EN
      lfsr        <= 16'hACE1;
`endif
    end else begin
      s1 <= sample_clk;
      s2 <= s1;
      s3 <= s2;
      case (state)
        IDLE: begin
          if (pulse) begin
            x1    <= sample_in1;
            x2    <= sample_in2;
            x3    <= sample_in3;
            k_r   <= k_map;
            state <= CH1;
          end
        end
        CH1: begin
          y1    <= y_new;
          state <= CH2;
        end
        CH2: begin
          y2    <= y_new;
          state <= CH3;
        end
        CH3: begin
          // Channel 3's result is still combinational here, so it commits directly.
          y3          <= y_new;
          sample_out1 <= y1;
          sample_out2 <= y2;
          sample_out3 <= y_new;
          state       <= IDLE;
`ifdef BITCRUSH_RESTORE_DITHER_EN
          lfsr        <= {lfsr[14:0], lfsr_fb};
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcrush_restore.sv
// Scoreboard bench for bitcrush_restore: stimulus queues expected outputs with
// their commit cycle, a negedge monitor compares every cycle.
module tb_bitcrush_restore;

  localparam int W = 16;

  typedef struct {
    int                  due;
    logic signed [W-1:0] o1;
    logic signed [W-1:0] o2;
    logic signed [W-1:0] o3;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sample_clk = 1'b0;
  logic signed [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic signed [W-1:0] out0, out1, out2, out3;
  logic [7:0]          jack = 8'h00;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b1;
  exp_t q[$];
  exp_t held = '{due: 0, o1: '0, o2: '0, o3: '0};

  bitcrush_restore #(.W(W), .KMAX(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_clk  (sample_clk),
    .sample_in0  (in0),
    .sample_in1  (in1),
    .sample_in2  (in2),
    .sample_in3  (in3),
    .sample_out0 (out0),
    .sample_out1 (out1),
    .sample_out2 (out2),
    .sample_out3 (out3),
    .jack        (jack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [W-1:0] act,
                       input logic signed [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic signed [W-1:0] act,
                             input int lo, input int hi);
    total++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected range [%0d,%0d]", name, cyc, act, lo, hi);
    end
  endtask

  // Monitor: retire expectations whose commit edge has passed, then compare.
  always @(negedge clk) begin
    if (mon_en && cyc >= 1) begin
      while (q.size() > 0 && q[0].due <= cyc) held = q.pop_front();
      check("out0", out0, in0);
      check("out1", out1, held.o1);
      check("out2", out2, held.o2);
      check("out3", out3, held.o3);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int due, input logic signed [W-1:0] e1,
                      input logic signed [W-1:0] e2, input logic signed [W-1:0] e3);
    exp_t e;
    e.due = due; e.o1 = e1; e.o2 = e2; e.o3 = e3;
    q.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    push(cyc + 1, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // One sample_clk rise; the next posedge is edge N, outputs change at N+5.
  task automatic send(input logic signed [W-1:0] c0, input logic signed [W-1:0] c1,
                      input logic signed [W-1:0] c2, input logic signed [W-1:0] c3,
                      input bit do_push, input logic signed [W-1:0] e1,
                      input logic signed [W-1:0] e2, input logic signed [W-1:0] e3);
    tick();
    in0 = c0; in1 = c1; in2 = c2; in3 = c3;
    sample_clk = 1'b1;
    if (do_push) push(cyc + 6, e1, e2, e3);
    tick();
    sample_clk = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    // Reset held with activity on every input.
    in1 = 1234; in2 = 1234; in3 = 1234;
    repeat (4) begin
      tick();
      sample_clk = ~sample_clk;
      in0 = in0 + 16'sd3000;
    end
    tick();
    sample_clk = 1'b0;
    in0 = 0;
    rst_n = 1'b1;
    repeat (3) tick();

`ifndef BITCRUSH_RESTORE_DITHER_EN
    // Pass-through with k=0.
    send(0, 1000, -500, 7, 1'b1, 1000, -500, 7);

    // k=5 step response from zero.
    do_reset();
    send(10400, 3200, 0, 0, 1'b1, 100, 0, 0);
    send(10400, 3200, 0, 0, 1'b1, 196, 0, 0);

    // k=1 negative full-scale, floor toward -inf.
    do_reset();
    send(2400, 0, -32768, 0, 1'b1, 0, -16384, 0);
    send(2400, 0, -32768, 0, 1'b1, 0, -24576, 0);

    // Second rise during processing is dropped; inputs change after capture;
    // sample_clk then held high must not retrigger.
    tick();
    in0 = 0; in1 = 11; in2 = 22; in3 = 33;
    sample_clk = 1'b1;
    c = cyc;
    push(c + 6, 11, 22, 33);
    tick();
    sample_clk = 1'b0;
    tick();
    sample_clk = 1'b1;
    tick();
    in1 = 99; in2 = 99; in3 = 99;
    repeat (12) tick();
    sample_clk = 1'b0;
    repeat (4) tick();

    // Reset while the FSM is in CH2: nothing commits, state returns to zero.
    tick();
    in0 = 0; in1 = 500; in2 = 500; in3 = 500;
    sample_clk = 1'b1;
    c = cyc;
    tick();
    sample_clk = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    push(c + 5, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Next sample starts from y=0 with k=1.
    send(2400, 100, -100, 7, 1'b1, 50, -50, 3);
`else
    // Dither: full-scale input must saturate and stay within 8 LSB below it.
    tick();
    mon_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send(0, 32767, 0, 0, 1'b0, 0, 0, 0);
      check_range("dither_out1", out1, 32759, 32767);
    end
`endif

    repeat (2) tick();
    check("queue_drained", 16'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
